// File: rtl/lift_floor_ctrl.sv
// ---------------------------------------------------------------------------
// lift_floor_ctrl
//
// Paternoster lift floor sequencer. It steps a cabin through floors 0..7 at a
// prescaled travel rate and reverses direction at each end of the shaft. When
// the cabin reaches a requested floor it dwells there, and it also handles run
// enable and emergency stop. Q feeds the downstream 7-segment decoder.
//
// Parameters
//   TICK_DIV     clk cycles per travel tick
//   DWELL_TICKS  travel ticks spent at a requested floor
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   run        in   level, 1 = lift allowed to travel
//   estop      in   level, emergency stop (highest priority)
//   req_valid  in   floor request valid
//   req_floor  in   [2:0] requested floor
//   req_ready  out  1 = no request pending, request taken on valid & ready
//   Q          out  [2:0] current floor
//   dir        out  1 = up, 0 = down
//   moving     out  1 while in MOVE
//   arrive     out  one-cycle pulse on reaching the pending floor
//   state      out  [1:0] IDLE=0, MOVE=1, DWELL=2, STOP=3
// ---------------------------------------------------------------------------
module lift_floor_ctrl #(
    parameter int unsigned TICK_DIV    = 100000000,
    parameter int unsigned DWELL_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       estop,
    input  logic       req_valid,
    input  logic [2:0] req_floor,
    output logic       req_ready,
    output logic [2:0] Q,
    output logic       dir,
    output logic       moving,
    output logic       arrive,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        DWELL = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [2:0]      floor_q, floor_d;
    logic            dir_q, dir_d;
    logic            pending_q, pending_d;
    logic [2:0]      pend_floor_q, pend_floor_d;
    logic            arrive_q, arrive_d;
    logic            moving_q, moving_d;
    logic            ready_q, ready_d;

    logic            timed;
    logic            tick;
    logic            arrived;
    logic            accept;

    // The prescaler only runs while travelling or dwelling.
    assign timed   = (state_q == MOVE) || (state_q == DWELL);
    assign tick    = timed && (presc_q == PRESC_LAST);
    assign arrived = pending_q && (floor_q == pend_floor_q);
    assign accept  = req_valid && ready_q;

    // ------------------------------------------------------------------
    // State register (plus all registered datapath and outputs)
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            dwell_q      <= '0;
            floor_q      <= 3'd0;
            dir_q        <= 1'b1;
            pending_q    <= 1'b0;
            pend_floor_q <= 3'd0;
            arrive_q     <= 1'b0;
            moving_q     <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            dwell_q      <= dwell_d;
            floor_q      <= floor_d;
            dir_q        <= dir_d;
            pending_q    <= pending_d;
            pend_floor_q <= pend_floor_d;
            arrive_q     <= arrive_d;
            moving_q     <= moving_d;
            ready_q      <= ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. In MOVE the priority is estop, run, arrival, tick.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (estop)    state_d = STOP;
                else if (run) state_d = MOVE;
            end
            MOVE: begin
                if (estop)        state_d = STOP;
                else if (!run)    state_d = IDLE;
                else if (arrived) state_d = DWELL;
            end
            DWELL: begin
                // run is only consulted at the end, so dropping it mid-dwell
                // never shortens the dwell.
                if (estop)
                    state_d = STOP;
                else if (tick && (dwell_q == DWELL_LAST))
                    state_d = run ? MOVE : IDLE;
            end
            STOP: begin
                // Re-arm requires run to be low as well as estop released.
                if (!estop && !run) state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic (computes next values of registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        floor_d      = floor_q;
        dir_d        = dir_q;
        pending_d    = pending_q;
        pend_floor_d = pend_floor_q;
        dwell_d      = dwell_q;
        arrive_d     = 1'b0;
        moving_d     = (state_d == MOVE);

        // Restart the prescaler on every state change so a partial count
        // (for example, one aborted by estop) never carries over.
        if ((state_d != state_q) || !timed || tick)
            presc_d = '0;
        else
            presc_d = presc_q + 1'b1;

        // Acceptance and arrival are exclusive: ready is low while pending.
        if (accept) begin
            pending_d    = 1'b1;
            pend_floor_d = req_floor;
        end

        unique case (state_q)
            MOVE: begin
                if (!estop && run) begin
                    if (arrived) begin
                        // Arrival wins over a coincident tick; no step.
                        arrive_d  = 1'b1;
                        pending_d = 1'b0;
                        dwell_d   = '0;
                    end else if (tick) begin
                        // At either end of the shaft, spend one tick reversing
                        // instead of stepping; the floor never wraps.
                        if (dir_q) begin
                            if (floor_q == 3'd7) dir_d   = 1'b0;
                            else                 floor_d = floor_q + 3'd1;
                        end else begin
                            if (floor_q == 3'd0) dir_d   = 1'b1;
                            else                 floor_d = floor_q - 3'd1;
                        end
                    end
                end
            end
            DWELL: begin
                if (!estop && tick)
                    dwell_d = (dwell_q == DWELL_LAST) ? '0 : dwell_q + 1'b1;
            end
            default: ;
        endcase

        ready_d = !pending_d && (state_d != STOP);
    end

    assign Q         = floor_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign arrive    = arrive_q;
    assign state     = state_q;
    assign req_ready = ready_q;

endmodule

// File: tb/tb_lift_floor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lift_floor_ctrl
//
// Self-checking bench for lift_floor_ctrl with TICK_DIV=4 and DWELL_TICKS=3.
// Each scenario task pushes the floor/direction changes and arrivals it
// expects. A negedge monitor pops those expectations as the DUT produces
// them, and it also checks the spacing between changes where the spacing is
// known. Scenario tasks add their own inline checks on state and handshake.
// ---------------------------------------------------------------------------
module tb_lift_floor_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int DWELL_TICKS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       estop;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       req_ready;
    logic [2:0] Q;
    logic       dir;
    logic       moving;
    logic       arrive;
    logic [1:0] state;

    lift_floor_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .DWELL_TICKS (DWELL_TICKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .estop     (estop),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .req_ready (req_ready),
        .Q         (Q),
        .dir       (dir),
        .moving    (moving),
        .arrive    (arrive),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] q;
        logic       d;
        int         gap;   // negedges since previous change, 0 = don't care
    } step_t;

    step_t      exp_q[$];
    logic [2:0] exp_arr[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_chg    = 0;
    int last_arr    = 0;
    bit mon_en      = 1'b0;
    logic [2:0] prev_q;
    logic       prev_dir;
    step_t      mon_e;
    logic [2:0] mon_f;

    // Monitor: pops the scoreboard whenever the DUT shows a change or an arrival.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_en) begin
            if ((Q !== prev_q) || (dir !== prev_dir)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL step_unexpected: got Q=%0d dir=%0d, none expected (t=%0t)", Q, dir, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ((Q !== mon_e.q) || (dir !== mon_e.d)) begin
                        miscompares++;
                        $display("FAIL step_value: got Q=%0d dir=%0d, want Q=%0d dir=%0d (t=%0t)",
                                 Q, dir, mon_e.q, mon_e.d, $time);
                    end
                    if ((mon_e.gap != 0) && ((cyc - last_chg) != mon_e.gap)) begin
                        miscompares++;
                        $display("FAIL step_gap: got %0d clks, want %0d before Q=%0d dir=%0d",
                                 cyc - last_chg, mon_e.gap, mon_e.q, mon_e.d);
                    end
                end
                last_chg = cyc;
            end
            if (arrive === 1'b1) begin
                vectors++;
                if (exp_arr.size() == 0) begin
                    miscompares++;
                    $display("FAIL arrive_unexpected: got arrive at Q=%0d, none expected (t=%0t)", Q, $time);
                end else begin
                    mon_f = exp_arr.pop_front();
                    if (Q !== mon_f) begin
                        miscompares++;
                        $display("FAIL arrive_floor: got Q=%0d, want %0d", Q, mon_f);
                    end
                end
                last_arr = cyc;
            end
        end else if ((Q !== prev_q) || (dir !== prev_dir)) begin
            last_chg = cyc;
        end
        prev_q   = Q;
        prev_dir = dir;
    end

    // Advance to just after the next falling edge (monitor has already run).
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_step(input logic [2:0] q, input logic d, input int gap);
        step_t s;
        s.q = q; s.d = d; s.gap = gap;
        exp_q.push_back(s);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (((exp_q.size() != 0) || (exp_arr.size() != 0)) && (n < budget)) begin
            step();
            n++;
        end
        vectors++;
        if ((exp_q.size() != 0) || (exp_arr.size() != 0)) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d steps %0d arrivals outstanding, want 0 after %0d clks",
                     name, exp_q.size(), exp_arr.size(), budget);
            exp_q.delete();
            exp_arr.delete();
        end
    endtask

    // Wait (bounded) until state equals or differs from a value.
    task automatic wait_state(input logic [1:0] s, input bit equal, input int budget, input string name);
        int n = 0;
        while (((state === s) != equal) && (n < budget)) begin
            step();
            n++;
        end
        vectors++;
        if ((state === s) != equal) begin
            miscompares++;
            $display("FAIL %s_timeout: got state=%0d after %0d clks", name, state, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; estop = 1'b0; req_valid = 1'b0; req_floor = 3'd0;
        step(); step();
        reset = 1'b0;
        vectors++; if (Q !== 3'd0)      begin miscompares++; $display("FAIL rst_q: got %0d want 0", Q); end
        vectors++; if (dir !== 1'b1)    begin miscompares++; $display("FAIL rst_dir: got %0b want 1", dir); end
        vectors++; if (state !== 2'd0)  begin miscompares++; $display("FAIL rst_state: got %0d want 0", state); end
        vectors++; if (moving !== 1'b0) begin miscompares++; $display("FAIL rst_moving: got %0b want 0", moving); end
        vectors++; if (arrive !== 1'b0) begin miscompares++; $display("FAIL rst_arrive: got %0b want 0", arrive); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
        mon_en = 1'b1;
    endtask

    // Full sweep up to 7, crossover, down to 0, crossover.
    task automatic test_sweep();
        push_step(3'd1, 1'b1, 0);
        for (int f = 2; f <= 7; f++) push_step(3'(f), 1'b1, TICK_DIV);
        push_step(3'd7, 1'b0, TICK_DIV);
        for (int f = 6; f >= 0; f--) push_step(3'(f), 1'b0, TICK_DIV);
        push_step(3'd0, 1'b1, TICK_DIV);
        run = 1'b1;
        step();
        vectors++; if (state !== 2'd1)  begin miscompares++; $display("FAIL sweep_state: got %0d want 1", state); end
        vectors++; if (moving !== 1'b1) begin miscompares++; $display("FAIL sweep_moving: got %0b want 1", moving); end
        drain(200, "sweep");
        run = 1'b0;
        step();
        vectors++; if (state !== 2'd0)  begin miscompares++; $display("FAIL sweep_idle: got %0d want 0", state); end
        vectors++; if (moving !== 1'b0) begin miscompares++; $display("FAIL sweep_moving_off: got %0b want 0", moving); end
    endtask

    // Request floor 5 from Q=2 going up; dwell 3 ticks then resume to 6.
    task automatic test_arrival();
        int n;
        push_step(3'd1, 1'b1, 0);
        push_step(3'd2, 1'b1, TICK_DIV);
        run = 1'b1;
        drain(40, "to_floor2");
        req_valid = 1'b1; req_floor = 3'd5;
        exp_arr.push_back(3'd5);
        push_step(3'd3, 1'b1, TICK_DIV);
        push_step(3'd4, 1'b1, TICK_DIV);
        push_step(3'd5, 1'b1, TICK_DIV);
        push_step(3'd6, 1'b1, 1 + DWELL_TICKS * TICK_DIV + TICK_DIV);
        step();
        req_valid = 1'b0;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL arr_ready_low: got %0b want 0", req_ready); end
        n = 0;
        while ((arrive !== 1'b1) && (n < 40)) begin step(); n++; end
        vectors++; if (state !== 2'd2)     begin miscompares++; $display("FAIL arr_dwell: got state=%0d want 2", state); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL arr_ready_high: got %0b want 1", req_ready); end
        drain(40, "arrival");
    endtask

    // Second request while one is pending is dropped.
    task automatic test_ignore();
        req_valid = 1'b1; req_floor = 3'd1;
        exp_arr.push_back(3'd1);
        step();
        req_floor = 3'd6;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ign_ready: got %0b want 0", req_ready); end
        step(); step();
        req_valid = 1'b0;
        push_step(3'd7, 1'b1, TICK_DIV);
        push_step(3'd7, 1'b0, TICK_DIV);
        for (int f = 6; f >= 1; f--) push_step(3'(f), 1'b0, TICK_DIV);
        push_step(3'd0, 1'b0, 1 + DWELL_TICKS * TICK_DIV + TICK_DIV);
        push_step(3'd0, 1'b1, TICK_DIV);
        drain(200, "ignore");
    endtask

    // estop at Q=4 mid-tick; re-arm requires cycling run.
    task automatic test_estop();
        int c0;
        for (int f = 1; f <= 4; f++) push_step(3'(f), 1'b1, TICK_DIV);
        drain(40, "to_floor4");
        step();
        estop = 1'b1;
        step();
        vectors++; if (state !== 2'd3)     begin miscompares++; $display("FAIL stop_state: got %0d want 3", state); end
        vectors++; if (moving !== 1'b0)    begin miscompares++; $display("FAIL stop_moving: got %0b want 0", moving); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL stop_ready: got %0b want 0", req_ready); end
        req_valid = 1'b1; req_floor = 3'd2;
        repeat (3) step();
        estop = 1'b0;
        repeat (5) step();
        req_valid = 1'b0;
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL stop_hold: got state=%0d want 3", state); end
        vectors++; if (Q !== 3'd4)     begin miscompares++; $display("FAIL stop_q: got %0d want 4", Q); end
        run = 1'b0;
        step();
        vectors++; if (state !== 2'd0)     begin miscompares++; $display("FAIL stop_rearm: got state=%0d want 0", state); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL stop_no_req: got ready=%0b want 1", req_ready); end
        push_step(3'd5, 1'b1, 0);
        c0 = cyc;
        run = 1'b1;
        drain(20, "resume");
        vectors++;
        if ((last_chg - c0) != 1 + TICK_DIV) begin
            miscompares++;
            $display("FAIL resume_latency: got %0d clks want %0d", last_chg - c0, 1 + TICK_DIV);
        end
    endtask

    // run drops mid-dwell: full dwell, then IDLE. Same-floor request
    // accepted in DWELL re-arrives on the first MOVE cycle.
    task automatic test_dwell_run_drop();
        int c0;
        int c_arr;
        req_valid = 1'b1; req_floor = 3'd6;
        exp_arr.push_back(3'd6);
        push_step(3'd6, 1'b1, TICK_DIV);
        step();
        req_valid = 1'b0;
        drain(40, "to_floor6");
        c_arr = last_arr;
        step();
        run = 1'b0;
        req_valid = 1'b1; req_floor = 3'd6;
        step();
        req_valid = 1'b0;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL dwell_req: got ready=%0b want 0", req_ready); end
        wait_state(2'd2, 1'b0, 30, "dwell_end");
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL dwell_idle: got state=%0d want 0", state); end
        vectors++; if (Q !== 3'd6)     begin miscompares++; $display("FAIL dwell_q: got %0d want 6", Q); end
        vectors++;
        if ((cyc - c_arr) != DWELL_TICKS * TICK_DIV) begin
            miscompares++;
            $display("FAIL dwell_len: got %0d clks want %0d", cyc - c_arr, DWELL_TICKS * TICK_DIV);
        end
        exp_arr.push_back(3'd6);
        c0 = cyc;
        run = 1'b1;
        drain(10, "rearrive");
        vectors++;
        if ((last_arr - c0) != 2) begin
            miscompares++;
            $display("FAIL rearrive_latency: got %0d clks want 2", last_arr - c0);
        end
        run = 1'b0;
        wait_state(2'd0, 1'b1, 30, "rearrive_idle");
    endtask

    // Reset mid-operation with Q=6, dir=0 and a request pending.
    task automatic test_reset_midop();
        push_step(3'd7, 1'b1, 0);
        push_step(3'd7, 1'b0, TICK_DIV);
        push_step(3'd6, 1'b0, TICK_DIV);
        run = 1'b1;
        drain(40, "to_floor6_down");
        req_valid = 1'b1; req_floor = 3'd2;
        step();
        req_valid = 1'b0;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL mid_pending: got ready=%0b want 0", req_ready); end
        mon_en = 1'b0;
        reset = 1'b1;
        step();
        vectors++; if (Q !== 3'd0)         begin miscompares++; $display("FAIL mid_q: got %0d want 0", Q); end
        vectors++; if (dir !== 1'b1)       begin miscompares++; $display("FAIL mid_dir: got %0b want 1", dir); end
        vectors++; if (state !== 2'd0)     begin miscompares++; $display("FAIL mid_state: got %0d want 0", state); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %0b want 1", req_ready); end
        vectors++; if (arrive !== 1'b0)    begin miscompares++; $display("FAIL mid_arrive: got %0b want 0", arrive); end
        vectors++; if (moving !== 1'b0)    begin miscompares++; $display("FAIL mid_moving: got %0b want 0", moving); end
        reset = 1'b0;
        run   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_arrival();
        test_ignore();
        test_estop();
        test_dwell_run_drop();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lift_floor_ctrl.md
Name: lift_floor_ctrl

Overview:
- Paternoster lift floor sequencer.
- Sits directly upstream of the 7-segment decoder: drives the 3-bit floor code Q that the decoder displays.
- Steps a cabin through floors 0..7 at a prescaled travel rate, reverses at the ends (crossover), and dwells at a requested floor.
- Handles run enable and emergency stop.

Parameters:
- TICK_DIV, 100000000: clk cycles per travel tick (1 s at 100 MHz); benches override with a small value (e.g. 4).
- DWELL_TICKS, 3: travel ticks spent at a requested floor before resuming.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- run  in  1  level; 1 = lift allowed to travel
- estop  in  1  level; emergency stop, highest priority
- req_valid  in  1  floor request valid
- req_floor  in  3  requested floor 0..7
- req_ready  out  1  1 = no request pending; request accepted on req_valid & req_ready
- Q  out  3  current floor, feeds decoder Q
- dir  out  1  1 = up, 0 = down
- moving  out  1  1 while in MOVE
- arrive  out  1  one-cycle pulse on reaching the pending floor
- state  out  2  IDLE=0, MOVE=1, DWELL=2, STOP=3

Behaviour:
- Reset (synchronous, sampled on rising clk): state=IDLE, Q=0, dir=1, moving=0, arrive=0, pending cleared (req_ready=1), prescaler=0, dwell counter=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in MOVE and DWELL.
  - tick=1 for the cycle it equals TICK_DIV-1, then wraps to 0.
  - Forced to 0 in IDLE and STOP and on every state entry.
- Request buffer:
  - One deep. On req_valid & req_ready, latch req_floor and set pending, so req_ready=0 the next cycle.
  - req_valid while req_ready=0 is ignored (no overwrite).
  - Requests are accepted in all states except STOP.
- IDLE:
  - estop -> STOP.
  - Else run=1 -> MOVE.
  - Otherwise hold.
- MOVE:
  - Priority order: estop, then run=0, then arrival, then tick.
  - estop -> STOP.
  - Else run=0 -> IDLE; Q and dir hold.
  - Else if pending and Q==pending floor -> DWELL:
    - arrive=1 for exactly this transition cycle.
    - Pending is cleared, so req_ready=1 the next cycle.
    - Dwell counter loads 0.
    - Arrival check takes precedence over a coincident tick; Q does not step that cycle.
  - Else on tick:
    - dir=1 and Q<7: Q+1.
    - dir=1 and Q==7: crossover, dir<=0, Q holds 7 for that tick.
    - dir=0 and Q>0: Q-1.
    - dir=0 and Q==0: dir<=1, Q holds 0.
    - Q never wraps 7->0 or 0->7.
- DWELL:
  - estop -> STOP.
  - Else count ticks; on the DWELL_TICKS-th tick go MOVE if run=1, else IDLE.
  - run dropping mid-dwell does not shorten the dwell.
  - A new request accepted during DWELL for the same floor is serviced on the first MOVE cycle (immediate re-arrival, no step).
- STOP:
  - Q, dir and pending hold; moving=0; req_ready forced 0.
  - Exit to IDLE only when estop=0 and run=0, so the operator must re-arm by cycling run.
  - estop asserted mid-tick aborts the partial prescaler count.
- moving is a registered decode of state==MOVE. arrive is registered. All outputs are registered, with no combinational path from inputs to outputs except req_ready, which is a registered decode of pending/state.
- Reset asserted mid-operation overrides everything in the same cycle.

Test Plan:
1. TICK_DIV=4, reset then run=1, no requests -> Q steps every 4 clks: 0,1,...,7; holds 7 one tick while dir goes 0; then 6,...,0; holds 0 while dir goes 1.
2. From Q=2 moving up, req_floor=5 accepted -> req_ready=0; arrive pulses one cycle when Q=5; state=DWELL for 3 ticks (12 clks); then MOVE, Q=6; req_ready=1 after arrival.
3. Request while req_ready=0 (floor 1 pending, then floor 6 valid) -> floor 6 ignored; only floor 1 produces arrive.
4. estop at Q=4 mid-MOVE -> state=STOP next cycle, Q stays 4. Releasing estop with run=1 keeps STOP; run=0 gives IDLE; run=1 gives MOVE, resuming from Q=4 in the same dir.
5. run=0 during DWELL (DWELL_TICKS=3) -> full 3-tick dwell completes, then IDLE; Q unchanged.
6. reset asserted with Q=6, dir=0, pending set -> next cycle Q=0, dir=1, state=IDLE, req_ready=1, arrive=0.
